// File: rtl/mfe_lcd1602_receiver_if.sv
// LCD1602 parallel bus as seen between the host controller and the display responder.
interface mfe_lcd1602_receiver_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data_i;
    logic [7:0] lcd_data_o;
    logic       lcd_data_oe;

    modport master (
        output lcd_rs, lcd_rw, lcd_en, lcd_data_i,
        input  lcd_data_o, lcd_data_oe
    );

    modport slave (
        input  lcd_rs, lcd_rw, lcd_en, lcd_data_i,
        output lcd_data_o, lcd_data_oe
    );
endinterface

// File: rtl/mfe_lcd1602_receiver.sv
// HD44780-compatible LCD1602 responder: 32-char buffer, mode flags, busy flag, bus reads.
// Define MFE_LCD1602_RX_BUSY_EN to model instruction busy timing; otherwise only the clear fill is busy.
module mfe_lcd1602_receiver #(
    parameter int unsigned T_BUSY      = 4000,
    parameter int unsigned T_BUSY_LONG = 164000
) (
    input  logic                        clk,
    input  logic                        rst,
    mfe_lcd1602_receiver_if.slave       bus,
    input  logic [4:0]                  rd_addr,
    output logic [7:0]                  rd_char,
    output logic                        busy,
    output logic                        disp_on,
    output logic                        cursor_on,
    output logic                        blink_on,
    output logic [6:0]                  ac,
    output logic                        drop
);

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h00)      return 7'h67;
            else if (a == 7'h40) return 7'h27;
            else                 return a - 7'd1;
        end
    endfunction

    // {visible, buffer index}: line 1 at 0x00-0x0F, line 2 at 0x40-0x4F
    function automatic logic [5:0] ddram_map(input logic [6:0] a);
        if (a <= 7'h0F)                     return {2'b10, a[3:0]};
        else if (a >= 7'h40 && a <= 7'h4F)  return {2'b11, a[3:0]};
        else                                return 6'd0;
    endfunction

    logic       en_p0, en_p1, en_p2;
    logic       rs_p0, rs_p1, rw_p0, rw_p1;
    logic [7:0] data_p0, data_p1;

    // Stage boundary: two-flop synchronizers, en_p2 only feeds edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            en_p0 <= 1'b0;
            en_p1 <= 1'b0;
            en_p2 <= 1'b0;
        end else begin
            en_p0 <= bus.lcd_en;
            en_p1 <= en_p0;
            en_p2 <= en_p1;
        end
        rs_p0   <= bus.lcd_rs;
        rs_p1   <= rs_p0;
        rw_p0   <= bus.lcd_rw;
        rw_p1   <= rw_p0;
        data_p0 <= bus.lcd_data_i;
        data_p1 <= data_p0;
    end

    logic       en_fall, en_rise;
    logic       fill_active;
    logic [4:0] fill_idx;
    logic       inc_mode, shift_en, dl, n_lines, font, cgram;
    logic       ac_vis;
    logic [4:0] ac_idx;
    logic [7:0] buf_mem [32];
    logic [7:0] cur_char;
    logic       instr_ok, data_ok, is_long;
    logic       mem_we;
    logic [4:0] mem_idx;
    logic [7:0] mem_wdata;
    logic       unused_mode;

    assign en_fall  = en_p2 & ~en_p1;
    assign en_rise  = en_p1 & ~en_p2;
    assign {ac_vis, ac_idx} = ddram_map(ac);
    assign cur_char = ac_vis ? buf_mem[ac_idx] : 8'h20;
    assign instr_ok = en_fall & ~rw_p1 & ~rs_p1 & ~busy;
    assign data_ok  = en_fall & ~rw_p1 &  rs_p1 & ~busy;
    assign is_long  = (data_p1[7:2] == 6'd0) && (data_p1[1:0] != 2'd0);
    // Mode bits kept for completeness; no port exposes them
    assign unused_mode = ^{shift_en, dl, n_lines, font};

`ifdef MFE_LCD1602_RX_BUSY_EN
    logic [17:0] busy_cnt;

    assign busy = fill_active | (busy_cnt != 18'd0);

    always_ff @(posedge clk) begin
        if (rst)
            busy_cnt <= 18'd0;
        else if (instr_ok || data_ok)
            busy_cnt <= (instr_ok && is_long) ? 18'(T_BUSY_LONG) : 18'(T_BUSY);
        else if (busy_cnt != 18'd0)
            busy_cnt <= busy_cnt - 18'd1;
    end
`else
    logic unused_busy_params;

    assign busy = fill_active;
    assign unused_busy_params = ^{18'(T_BUSY), 18'(T_BUSY_LONG)};
`endif

    // The clear/reset fill owns the write port; host writes are dropped while it runs
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = fill_idx;
        mem_wdata = 8'h20;
        if (fill_active) begin
            mem_we = 1'b1;
        end else if (data_ok && !cgram && ac_vis) begin
            mem_we    = 1'b1;
            mem_idx   = ac_idx;
            mem_wdata = data_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) buf_mem[mem_idx] <= mem_wdata;
    end

    // Stage boundary: decode and architectural state, updated on the synced en fall
    always_ff @(posedge clk) begin
        drop <= 1'b0;
        if (rst) begin
            fill_active     <= 1'b1;
            fill_idx        <= 5'd0;
            ac              <= 7'd0;
            inc_mode        <= 1'b1;
            shift_en        <= 1'b0;
            disp_on         <= 1'b0;
            cursor_on       <= 1'b0;
            blink_on        <= 1'b0;
            dl              <= 1'b1;
            n_lines         <= 1'b1;
            font            <= 1'b0;
            cgram           <= 1'b0;
            bus.lcd_data_oe <= 1'b0;
            bus.lcd_data_o  <= 8'h00;
            rd_char         <= 8'h00;
        end else begin
            rd_char         <= buf_mem[rd_addr];
            bus.lcd_data_oe <= en_p1 & rw_p1;
            if (en_rise)
                bus.lcd_data_o <= rs_p1 ? cur_char : {busy, ac};
            if (fill_active) begin
                fill_idx <= fill_idx + 5'd1;
                if (fill_idx == 5'd31) fill_active <= 1'b0;
            end
            if (en_fall) begin
                if (rw_p1) begin
                    if (rs_p1) ac <= ac_step(ac, inc_mode);
                end else if (busy) begin
                    drop <= 1'b1;
                end else if (rs_p1) begin
                    if (cgram || !ac_vis) drop <= 1'b1;
                    if (!cgram) ac <= ac_step(ac, inc_mode);
                end else begin
                    casez (data_p1)
                        8'b1???????: begin ac <= data_p1[6:0]; cgram <= 1'b0; end
                        8'b01??????: cgram <= 1'b1;
                        8'b001?????: begin
                            dl      <= data_p1[4];
                            n_lines <= data_p1[3];
                            font    <= data_p1[2];
                        end
                        8'b0001????: if (!data_p1[3]) ac <= ac_step(ac, data_p1[2]);
                        8'b00001???: begin
                            disp_on   <= data_p1[2];
                            cursor_on <= data_p1[1];
                            blink_on  <= data_p1[0];
                        end
                        8'b000001??: begin inc_mode <= data_p1[1]; shift_en <= data_p1[0]; end
                        8'b0000001?: ac <= 7'd0;
                        8'b00000001: begin
                            ac          <= 7'd0;
                            inc_mode    <= 1'b1;
                            cgram       <= 1'b0;
                            fill_active <= 1'b1;
                            fill_idx    <= 5'd0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mfe_lcd1602_receiver.sv
// Directed bench for mfe_lcd1602_receiver: buffer writes, ac wrap, reads, clear/drop, reset.
module tb_mfe_lcd1602_receiver;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       busy, disp_on, cursor_on, blink_on, drop;
  logic [6:0] ac;
  int         checks = 0;
  int         errors = 0;
  int         drops = 0;
  int         d0;

  always #5 clk = ~clk;

  mfe_lcd1602_receiver_if bus();

  mfe_lcd1602_receiver #(.T_BUSY(20), .T_BUSY_LONG(300)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rd_addr(rd_addr), .rd_char(rd_char),
    .busy(busy), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .ac(ac), .drop(drop)
  );

  always @(negedge clk) if (drop === 1'b1) drops++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy !== 1'b0; i++) @(negedge clk);
    check("idle_bound", {31'd0, busy}, 32'd0);
  endtask

  task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data_i = d;
    bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    bus.lcd_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    wait_idle();
    bus_cycle(rs, 1'b0, d);
  endtask

  task automatic read_chk(input logic rs, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = 1'b1;
    bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    check({tag, "_oe"}, {31'd0, bus.lcd_data_oe}, 32'd1);
    check(tag, {24'd0, bus.lcd_data_o}, {24'd0, exp});
    bus.lcd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_oe_off"}, {31'd0, bus.lcd_data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    bus.lcd_rw = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check(tag, {24'd0, rd_char}, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_en = 1'b0; bus.lcd_data_i = 8'h00;
    rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_ac", {25'd0, ac}, 32'd0);
    check("rst_oe", {31'd0, bus.lcd_data_oe}, 32'd0);
    check("rst_data_o", {24'd0, bus.lcd_data_o}, 32'd0);
    check("rst_rd_char", {24'd0, rd_char}, 32'd0);
    check("rst_flags", {29'd0, disp_on, cursor_on, blink_on}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("fill_busy", {31'd0, busy}, 32'd1);
    repeat (40) @(negedge clk);
    check("fill_done", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 32; i++) peek(5'(i), 8'h20, "init_buf");

    wr(0, 8'h80); wr(1, 8'h57); wr(1, 8'h65);
    peek(5'd0, 8'h57, "idx0_W");
    peek(5'd1, 8'h65, "idx1_e");
    check("ac_after_two", {25'd0, ac}, 32'h02);

    wr(0, 8'hC0); wr(1, 8'h44);
    peek(5'd16, 8'h44, "idx16_D");
    check("ac_line2", {25'd0, ac}, 32'h41);

    wr(0, 8'h8F); wr(1, 8'h41);
    d0 = drops;
    wr(1, 8'h42);
    peek(5'd15, 8'h41, "idx15_A");
    check("drop_invisible", 32'(drops - d0), 32'd1);
    check("ac_invisible", {25'd0, ac}, 32'h11);

    wr(0, 8'h0F);
    check("dctl_all", {29'd0, disp_on, cursor_on, blink_on}, 32'b111);
    wr(0, 8'h0C);
    check("dctl_disp", {29'd0, disp_on, cursor_on, blink_on}, 32'b100);

    wr(0, 8'hA7); wr(1, 8'h31);
    check("wrap_inc_27", {25'd0, ac}, 32'h40);
    peek(5'd16, 8'h44, "idx16_kept");

    wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h58);
    check("wrap_dec_00", {25'd0, ac}, 32'h67);
    peek(5'd0, 8'h58, "idx0_X");

    wr(0, 8'h14);
    check("cur_right_67", {25'd0, ac}, 32'h00);
    wr(0, 8'h10);
    check("cur_left_00", {25'd0, ac}, 32'h67);
    wr(0, 8'h1C);
    check("disp_shift_ign", {25'd0, ac}, 32'h67);
    wr(0, 8'hC0); wr(0, 8'h10);
    check("cur_left_40", {25'd0, ac}, 32'h27);

    wait_idle();
    read_chk(0, 8'h27, "status_rd");
    check("status_no_step", {25'd0, ac}, 32'h27);

    wr(0, 8'h06); wr(0, 8'h80);
    wait_idle();
    read_chk(1, 8'h58, "data_rd");
    check("data_rd_step", {25'd0, ac}, 32'h01);

    wr(0, 8'h02);
    check("home_ac", {25'd0, ac}, 32'h00);
    peek(5'd0, 8'h58, "home_keeps_buf");

    wr(0, 8'h01);
    d0 = drops;
    bus_cycle(1, 0, 8'h5A);
    check("drop_during_clear", 32'(drops - d0), 32'd1);
    read_chk(0, 8'h80, "status_busy");
    repeat (100) @(negedge clk);
`ifdef MFE_LCD1602_RX_BUSY_EN
    read_chk(0, 8'h80, "status_busy_long");
`else
    read_chk(0, 8'h00, "status_after_fill");
`endif
    wait_idle();
    read_chk(0, 8'h00, "status_idle");
    for (int i = 0; i < 32; i++) peek(5'(i), 8'h20, "clear_buf");
    check("clear_ac", {25'd0, ac}, 32'h00);

    wr(1, 8'h77);
    peek(5'd0, 8'h77, "post_clear_wr");
    wr(0, 8'h40);
    d0 = drops;
    wr(1, 8'h11);
    check("drop_cgram", 32'(drops - d0), 32'd1);
    peek(5'd1, 8'h20, "cgram_no_wr");
    wr(0, 8'h81);
    d0 = drops;
    wr(1, 8'h22);
    peek(5'd1, 8'h22, "ddram_again");
    check("no_drop_ddram", 32'(drops - d0), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    check("midrst_ac", {25'd0, ac}, 32'h00);
    check("midrst_flags", {29'd0, disp_on, cursor_on, blink_on}, 32'd0);
    repeat (40) @(negedge clk);
    check("midrst_idle", {31'd0, busy}, 32'd0);
    peek(5'd0, 8'h20, "midrst_idx0");
    peek(5'd1, 8'h20, "midrst_idx1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mfe_lcd1602_receiver.md
Name: mfe_lcd1602_receiver

Overview:
- Synthesizable HD44780-compatible responder for the LCD1602 parallel bus. It is the device end of the bus driven by the team's LCD controller.
- Samples lcd_rs/lcd_rw/lcd_en/lcd_data and decodes the 8-bit instruction set into a 32-character display buffer plus mode flags.
- Models the busy flag and answers bus reads.
- Used as an on-FPGA loopback target and as the scoreboard source for controller/demo regression.

Parameters:
- T_BUSY, 4000, busy cycles after a normal instruction or data write (40 us at 100 MHz).
- T_BUSY_LONG, 164000, busy cycles after clear/home (1.64 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- lcd_rs  in  1  register select (0 instruction, 1 data)
- lcd_rw  in  1  0 write, 1 read
- lcd_en  in  1  enable strobe; bus is asynchronous to clk
- lcd_data_i  in  8  bus data from host
- lcd_data_o  out  8  read data to host
- lcd_data_oe  out  1  drive enable for lcd_data_o
- busy  out  1  internal busy flag
- rd_addr  in  5  buffer snoop index (0-15 line 1, 16-31 line 2)
- rd_char  out  8  buffer content at rd_addr, registered, 1-cycle latency
- disp_on, cursor_on, blink_on  out  1 each  display-control flags
- ac  out  7  address counter
- drop  out  1  one-cycle pulse: write ignored (busy, CGRAM, or invisible address)

Behaviour:
- Input sync: 2-flop synchronizers on all bus inputs. A write/read completes on a falling edge of synced en. Data/rs/rw are captured from the synced stage at that edge. Latency from the en fall at the pin to the state update is 3 clk.
- Reset values:
  - Buffer filled with 0x20 (32-cycle sequential fill); busy=1 during the fill.
  - ac=0, I/D=1 (increment), S=0.
  - disp_on=0, cursor_on=0, blink_on=0.
  - dl=1, n=1, f=0.
  - lcd_data_oe=0, lcd_data_o=0, rd_char=0, drop=0.
- Instruction decode (rs=0, rw=0), by highest set bit:
  - 0x01 clear: 32-cycle fill with 0x20, ac=0, I/D=1, busy for T_BUSY_LONG.
  - 0x02/0x03 home: ac=0, buffer unchanged, busy for T_BUSY_LONG.
  - 0x04-0x07 entry mode: I/D=bit1, S=bit0. S is stored only; display shift is not implemented.
  - 0x08-0x0F display control: D/C/B from bits 2/1/0.
  - 0x10-0x1F: if bit3=0, cursor move (bit2=1 ac+1, else ac-1) with the wrap rules below. Display shift (bit3=1) is accepted and ignored.
  - 0x20-0x3F function set: dl/n/f stored.
  - 0x40-0x7F set CGRAM address: enter CGRAM mode; subsequent data writes pulse drop.
  - 0x80-0xFF set DDRAM address: ac=data[6:0], leave CGRAM mode.
  - Every instruction except clear/home loads busy for T_BUSY.
- Data write (rs=1, rw=0), DDRAM mode:
  - Visible ac 0x00-0x0F maps to index ac; 0x40-0x4F maps to index 16+(ac-0x40). Write the buffer at that index.
  - Any other ac: no write, drop=1.
  - Then step ac per I/D and load busy for T_BUSY.
- ac wrap:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
- Writes during busy: ignored entirely (no state change), drop=1.
- Reads (rw=1):
  - lcd_data_oe=1 while synced en=1; lcd_data_o is stable during the high phase.
  - rs=0 returns {busy, ac}.
  - rs=1 returns the buffer char at ac (0x20 if ac is invisible); ac steps on en fall, busy is unaffected.
  - Busy-flag reads are always honoured, even while busy.
- Busy counter: 18-bit down-counter; busy = (cnt!=0) | fill_active. A new load while busy cannot occur, because writes are dropped.
- Simultaneous events: a snoop read on the same cycle as a buffer write returns the old value.
- rst mid-operation: aborts fill/busy and restarts the reset fill.
- dl=0 (4-bit mode) is not supported. Every byte is treated as 8-bit and the flag is stored only.

Optional Feature:
- MFE_LCD1602_RX_BUSY_EN.
- Defined: busy timing modeled as above; writes during busy are dropped.
- Undefined: busy is driven only by the clear/reset fill (≤32 cycles); T_BUSY/T_BUSY_LONG are unused. Controller benches run fast, but writes arriving during a clear fill are still dropped.

Test Plan:
- Reset, wait 32 cycles -> busy=0; rd_char=0x20 for rd_addr 0..31; ac=0.
- Write 0x80, then data 0x57 0x65 -> idx0=0x57, idx1=0x65, ac=0x02.
- Write 0xC0, then data 0x44 -> idx16=0x44, ac=0x41. Write 0x8F, then data 0x41 0x42 -> idx15=0x41; 0x42 dropped (ac=0x10 invisible), drop pulse.
- With MFE_LCD1602_RX_BUSY_EN: issue 0x01, then a data write 100 cycles later -> drop=1, buffer all 0x20. A status read returns bit7=1 until 164000 cycles have elapsed.
- Set ac=0x27 with I/D=1, write data -> ac=0x40. Write 0x04 (I/D=0), set ac=0x00, write data -> ac=0x67.
- Status read with rs=0, rw=1, en high -> lcd_data_oe=1, lcd_data_o={busy,ac}. After en falls, lcd_data_oe=0 within 3 clk.
